// File: rtl/ber_align_counter.sv
// BER checker behind the slicer: searches a PRBS reference delay line for the
// delay that matches the received bits, then counts compared bits and errors.
`timescale 1ns/1ps
module ber_align_counter #(
    parameter int DEPTH   = 512,
    parameter int WINDOW  = 511,
    parameter int LOL_THR = 127,
    parameter int CNT_W   = 64
) (
    input  logic                     clock,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_bit_rx,
    input  logic                     i_bit_ref,
    input  logic                     i_resync,
    output logic                     o_locked,
    output logic [$clog2(DEPTH)-1:0] o_delay,
    output logic [CNT_W-1:0]         o_bit_count,
    output logic [CNT_W-1:0]         o_err_count,
    output logic                     o_sat,
    output logic [1:0]               o_state
);

    localparam int DW = $clog2(DEPTH);
    localparam int WW = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DEPTH-2:0]   ref_sr_q, ref_sr_d;
    logic [DW-1:0]      fill_q, fill_d;
    logic [WW-1:0]      win_q, win_d;
    logic [WW-1:0]      errw_q, errw_d;
    logic [DW-1:0]      delay_q, delay_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic               sat_q, sat_d;

    logic [DEPTH-1:0]   refvec;
    logic               mis;
    logic [WW-1:0]      total;
    logic               win_end;
    logic [DW-1:0]      delay_next;
    logic               sat_hit;

    // Index k of refvec is the reference bit from k enables ago.
    assign refvec     = {ref_sr_q, i_bit_ref};
    assign mis        = i_bit_rx ^ refvec[delay_q];
    assign total      = errw_q + WW'(mis);
    assign win_end    = (win_q == WW'(WINDOW - 1));
    assign delay_next = (delay_q == DW'(DEPTH - 1)) ? '0 : delay_q + 1'b1;
    assign sat_hit    = (bit_q == '1) || (mis && (err_q == '1));

    always_comb begin
        state_d  = state_q;
        ref_sr_d = ref_sr_q;
        fill_d   = fill_q;
        win_d    = win_q;
        errw_d   = errw_q;
        delay_d  = delay_q;
        bit_d    = bit_q;
        err_d    = err_q;
        sat_d    = sat_q;

        if (i_enable) begin
            ref_sr_d = {ref_sr_q[DEPTH-3:0], i_bit_ref};
            case (state_q)
                FILL: begin
                    if (fill_q == DW'(DEPTH - 2)) begin
                        state_d = ALIGN;
                        fill_d  = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                ALIGN: begin
                    if (win_end) begin
                        win_d  = '0;
                        errw_d = '0;
                        if (total == '0) state_d = LOCKED;
                        else             delay_d = delay_next;
                    end else begin
                        win_d  = win_q + 1'b1;
                        errw_d = total;
                    end
                end
                LOCKED: begin
                    // Once either counter would wrap, both stay frozen until resync.
                    if (!sat_q) begin
                        if (sat_hit) begin
                            sat_d = 1'b1;
                        end else begin
                            bit_d = bit_q + 1'b1;
                            err_d = err_q + CNT_W'(mis);
                        end
                    end
                    if (win_end) begin
                        win_d  = '0;
                        errw_d = '0;
                        if (32'(total) > 32'(LOL_THR)) begin
                            state_d = ALIGN;
                            delay_d = delay_next;
                        end
                    end else begin
                        win_d  = win_q + 1'b1;
                        errw_d = total;
                    end
                end
                default: state_d = FILL;
            endcase
        end

        // Resync overrides any window decision taken above; FILL just keeps filling.
        if (i_resync && (state_q != FILL)) begin
            state_d = ALIGN;
            delay_d = '0;
            win_d   = '0;
            errw_d  = '0;
            bit_d   = '0;
            err_d   = '0;
            sat_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= FILL;
            ref_sr_q <= '0;
            fill_q   <= '0;
            win_q    <= '0;
            errw_q   <= '0;
            delay_q  <= '0;
            bit_q    <= '0;
            err_q    <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_sr_q <= ref_sr_d;
            fill_q   <= fill_d;
            win_q    <= win_d;
            errw_q   <= errw_d;
            delay_q  <= delay_d;
            bit_q    <= bit_d;
            err_q    <= err_d;
            sat_q    <= sat_d;
        end
    end

    assign o_locked    = (state_q == LOCKED);
    assign o_delay     = delay_q;
    assign o_bit_count = bit_q;
    assign o_err_count = err_q;
    assign o_sat       = sat_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_ber_align_counter.sv
// Bench for ber_align_counter, scaled to DEPTH=64 / WINDOW=63 with a PRBS6
// reference so full search, wrap and relock fit in a short run.
`timescale 1ns/1ps
module tb_ber_align_counter;

    localparam logic [1:0] ST_F = 2'd0;
    localparam logic [1:0] ST_A = 2'd1;
    localparam logic [1:0] ST_K = 2'd2;
    localparam int         PW   = 138;

    logic        clock;
    logic        i_reset;
    logic        i_enable;
    logic        i_bit_ref;
    logic        i_bit_rx;
    logic        i_bit_rx2;
    logic        i_resync;
    logic        i_resync2;

    logic        l1, s1, l2, s2;
    logic [5:0]  d1, d2;
    logic [1:0]  st1, st2;
    logic [63:0] b1, e1;
    logic [7:0]  b2, e2;

    // Main instance: LOL_THR well below the window size.
    ber_align_counter #(.DEPTH(64), .WINDOW(63), .LOL_THR(15), .CNT_W(64)) dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable),
        .i_bit_rx(i_bit_rx), .i_bit_ref(i_bit_ref), .i_resync(i_resync),
        .o_locked(l1), .o_delay(d1), .o_bit_count(b1), .o_err_count(e1),
        .o_sat(s1), .o_state(st1)
    );

    // Narrow counters and a threshold that can never trip, so errors saturate while locked.
    ber_align_counter #(.DEPTH(64), .WINDOW(63), .LOL_THR(63), .CNT_W(8)) dut_sat (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable),
        .i_bit_rx(i_bit_rx2), .i_bit_ref(i_bit_ref), .i_resync(i_resync2),
        .o_locked(l2), .o_delay(d2), .o_bit_count(b2), .o_err_count(e2),
        .o_sat(s2), .o_state(st2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [PW-1:0] exp_q[$];
    string         nm_q[$];

    logic [5:0]    lfsr;
    logic [127:0]  hist;
    int            rx_delay;
    bit            inv, inv2;

    typedef struct {
        string       name;
        int          n_en;
        int          gap;
        bit          inv;
        bit          inv2;
        int          flip_per;
        logic [1:0]  st1;
        logic        l1;
        logic [5:0]  d1;
        logic [63:0] b1;
        logic [63:0] e1;
        logic        s1;
        logic [1:0]  st2;
        logic        l2;
        logic [5:0]  d2;
        logic [63:0] b2;
        logic [63:0] e2;
        logic        s2;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [PW-1:0] pk(input logic [1:0] st, input logic lk, input logic [5:0] dl,
                                         input logic [63:0] bc, input logic [63:0] ec, input logic sa);
        return {st, lk, dl, bc, ec, sa};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input string nm, input logic [PW-1:0] e);
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic score(input int which);
        logic [PW-1:0] ev, av;
        string         nm;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got no expected entry, expected one queued");
            return;
        end
        ev = exp_q.pop_front();
        nm = nm_q.pop_front();
        av = (which == 1) ? pk(st1, l1, d1, b1, e1, s1)
                          : pk(st2, l2, d2, 64'(b2), 64'(e2), s2);
        if (av !== ev) begin
            n_fail++;
            $display("FAIL %s/inst%0d: got st=%0d lock=%0b dly=%0d bits=%0d errs=%0d sat=%0b, expected st=%0d lock=%0b dly=%0d bits=%0d errs=%0d sat=%0b",
                     nm, which, av[137:136], av[135], av[134:129], av[128:65], av[64:1], av[0],
                     ev[137:136], ev[135], ev[134:129], ev[128:65], ev[64:1], ev[0]);
        end
    endtask

    // One symbol: enable for one clock, then 'gap' idle clocks with junk on the data pins.
    task automatic en_step(input int gap, input bit flip, input bit rs);
        logic ref_now, base;
        ref_now   = lfsr[5];
        base      = (rx_delay == 0) ? ref_now : hist[rx_delay-1];
        i_enable  = 1'b1;
        i_bit_ref = ref_now;
        i_bit_rx  = base ^ inv ^ flip;
        i_bit_rx2 = base ^ inv ^ flip ^ inv2;
        i_resync  = rs;
        tick();
        hist      = {hist[126:0], ref_now};
        lfsr      = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
        i_enable  = 1'b0;
        i_resync  = 1'b0;
        i_bit_ref = 1'($urandom_range(0, 1));
        i_bit_rx  = 1'($urandom_range(0, 1));
        i_bit_rx2 = 1'($urandom_range(0, 1));
        repeat (gap) tick();
    endtask

    task automatic add_vec(input string nm, input int n, input int gap, input bit iv, input bit iv2,
                           input int fp,
                           input logic [1:0] xs1, input logic xl1, input logic [5:0] xd1,
                           input logic [63:0] xb1, input logic [63:0] xe1, input logic xsa1,
                           input logic [1:0] xs2, input logic xl2, input logic [5:0] xd2,
                           input logic [63:0] xb2, input logic [63:0] xe2, input logic xsa2);
        vec_t v;
        v.name = nm; v.n_en = n; v.gap = gap; v.inv = iv; v.inv2 = iv2; v.flip_per = fp;
        v.st1 = xs1; v.l1 = xl1; v.d1 = xd1; v.b1 = xb1; v.e1 = xe1; v.s1 = xsa1;
        v.st2 = xs2; v.l2 = xl2; v.d2 = xd2; v.b2 = xb2; v.e2 = xe2; v.s2 = xsa2;
        vecs.push_back(v);
    endtask

    initial begin
        bit flip;
        i_reset = 1'b0; i_enable = 1'b0; i_bit_ref = 1'b0; i_bit_rx = 1'b0;
        i_bit_rx2 = 1'b0; i_resync = 1'b0; i_resync2 = 1'b0;
        lfsr = 6'h3F; hist = '0; rx_delay = 37; inv = 1'b0; inv2 = 1'b0;

        // Fill takes 63 enables; each candidate delay gets a 63-enable window, so the
        // delay-37 window closes on enable 63 + 38*63 = 2457.
        //       name          n     gap inv inv2 flip | inst1 st,lk,dly,bits,errs,sat | inst2
        add_vec("fill_align", 2456, 3, 0, 0, 0,   ST_A, 0, 37, 0,    0,  0, ST_A, 0, 37, 0,   0,   0);
        add_vec("lock",       1,    3, 0, 0, 0,   ST_K, 1, 37, 0,    0,  0, ST_K, 1, 37, 0,   0,   0);
        add_vec("clean",      100,  1, 0, 1, 0,   ST_K, 1, 37, 100,  0,  0, ST_K, 1, 37, 100, 100, 0);
        add_vec("flips",      1901, 0, 0, 1, 633, ST_K, 1, 37, 2001, 3,  0, ST_K, 1, 37, 255, 255, 1);
        add_vec("thr_edge",   15,   0, 1, 1, 0,   ST_K, 1, 37, 2016, 18, 0, ST_K, 1, 37, 255, 255, 1);
        add_vec("lol",        63,   0, 1, 1, 0,   ST_A, 0, 38, 2079, 81, 0, ST_K, 1, 37, 255, 255, 1);
        add_vec("wrap",       1638, 0, 1, 1, 0,   ST_A, 0, 0,  2079, 81, 0, ST_K, 1, 37, 255, 255, 1);
        add_vec("relock",     2394, 0, 0, 1, 0,   ST_K, 1, 37, 2079, 81, 0, ST_K, 1, 37, 255, 255, 1);
        add_vec("recount",    10,   3, 0, 1, 0,   ST_K, 1, 37, 2089, 81, 0, ST_K, 1, 37, 255, 255, 1);

        repeat (2) tick();
        push_exp("reset", pk(ST_F, 0, 0, 0, 0, 0)); score(1);
        push_exp("reset", pk(ST_F, 0, 0, 0, 0, 0)); score(2);
        i_reset = 1'b1;
        tick();

        foreach (vecs[k]) begin
            inv  = vecs[k].inv;
            inv2 = vecs[k].inv2;
            for (int i = 0; i < vecs[k].n_en; i++) begin
                flip = (vecs[k].flip_per != 0) && ((i % vecs[k].flip_per) == (vecs[k].flip_per / 2));
                if (i == vecs[k].n_en - 1) begin
                    push_exp(vecs[k].name, pk(vecs[k].st1, vecs[k].l1, vecs[k].d1, vecs[k].b1, vecs[k].e1, vecs[k].s1));
                    push_exp(vecs[k].name, pk(vecs[k].st2, vecs[k].l2, vecs[k].d2, vecs[k].b2, vecs[k].e2, vecs[k].s2));
                end
                en_step(vecs[k].gap, flip, 1'b0);
            end
            score(1);
            score(2);
        end

        // Idle clocks with junk data must not move anything.
        push_exp("gate_hold", pk(ST_K, 1, 37, 2089, 81, 0));
        repeat (5) begin
            i_bit_rx = 1'($urandom_range(0, 1));
            i_bit_ref = 1'($urandom_range(0, 1));
            tick();
        end
        score(1);

        push_exp("resync2_clear", pk(ST_A, 0, 0, 0, 0, 0));
        i_resync2 = 1'b1; tick(); i_resync2 = 1'b0;
        score(2);

        push_exp("resync_locked", pk(ST_A, 0, 0, 0, 0, 0));
        i_resync = 1'b1; tick(); i_resync = 1'b0;
        score(1);

        // Delay-0 stream: the first window would lock, but resync lands on its last enable.
        rx_delay = 0; inv = 1'b0;
        push_exp("win_mid", pk(ST_A, 0, 0, 0, 0, 0));
        repeat (62) en_step(0, 1'b0, 1'b0);
        score(1);
        push_exp("resync_winend", pk(ST_A, 0, 0, 0, 0, 0));
        en_step(0, 1'b0, 1'b1);
        score(1);
        push_exp("relock_pre", pk(ST_A, 0, 0, 0, 0, 0));
        repeat (62) en_step(0, 1'b0, 1'b0);
        score(1);
        push_exp("relock_d0", pk(ST_K, 1, 0, 0, 0, 0));
        en_step(0, 1'b0, 1'b0);
        score(1);
        push_exp("count_d0", pk(ST_K, 1, 0, 5, 0, 0));
        repeat (5) en_step(0, 1'b0, 1'b0);
        score(1);

        // Reset between clock edges must clear everything immediately.
        #2;
        i_reset = 1'b0;
        #1;
        push_exp("async_reset", pk(ST_F, 0, 0, 0, 0, 0)); score(1);
        push_exp("async_reset", pk(ST_F, 0, 0, 0, 0, 0)); score(2);
        tick();
        i_reset = 1'b1;
        tick();

        // Resync during fill leaves the fill count running.
        repeat (10) en_step(0, 1'b0, 1'b0);
        push_exp("fill_resync", pk(ST_F, 0, 0, 0, 0, 0));
        en_step(0, 1'b0, 1'b1);
        score(1);
        push_exp("fill_62", pk(ST_F, 0, 0, 0, 0, 0));
        repeat (51) en_step(0, 1'b0, 1'b0);
        score(1);
        push_exp("fill_done", pk(ST_A, 0, 0, 0, 0, 0));
        en_step(0, 1'b0, 1'b0);
        score(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
